// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues instruction SRAM reads and the IF->ID bus.
// A branch resolved while IF is stalled is latched and replayed when the stall releases.
module if_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hBFBF_FFFC,
  parameter int          IF_TO_ID_WD = 33,
  parameter int          STALL_WD    = 6,
  parameter int          BR_WD       = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic        ce_reg, ce_nxt;
  logic        br_pend, pend_nxt;
  logic [31:0] br_tgt_r, tgt_nxt;

  logic        stop;
  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] next_pc;
  logic        unused_stall_bits;

  assign stop              = stall[0];
  assign br_e              = br_bus[BR_WD-1];
  assign br_addr           = br_bus[31:0];
  assign unused_stall_bits = ^stall[STALL_WD-1:1];

  // An already-latched redirect outranks a branch arriving on the release cycle.
  assign next_pc = br_pend ? br_tgt_r :
                   br_e    ? br_addr  :
                             pc_reg + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc_reg   <= RESET_PC;
      ce_reg   <= 1'b0;
      br_pend  <= 1'b0;
      br_tgt_r <= 32'd0;
    end else begin
      state    <= state_nxt;
      pc_reg   <= pc_nxt;
      ce_reg   <= ce_nxt;
      br_pend  <= pend_nxt;
      br_tgt_r <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    ce_nxt    = ce_reg;
    pend_nxt  = br_pend;
    tgt_nxt   = br_tgt_r;
    unique case (state)
      BOOT: begin
        ce_nxt    = 1'b1;
        pc_nxt    = RESET_PC + 32'd4;
        state_nxt = RUN;
      end
      RUN: begin
        if (!stop) begin
          pc_nxt = next_pc;
        end else begin
          if (br_e) begin
            pend_nxt = 1'b1;
            tgt_nxt  = br_addr;
          end
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          if (br_e) begin
            pend_nxt = 1'b1;
            tgt_nxt  = br_addr;
          end
        end else begin
          pc_nxt    = next_pc;
          pend_nxt  = 1'b0;
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_en    = ce_reg;
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed and random checks of if_fetch against a cycle-level reference model.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [32:0] br_bus = '0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch address, enable, pending redirect, booted flag.
  logic [31:0] m_pc;
  logic        m_en;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_booted;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_en     = 1'b0;
    m_pend   = 1'b0;
    m_tgt    = 32'd0;
    m_booted = 1'b0;
  endtask

  // Applies one clock edge worth of the fetch rules using the inputs present at that edge.
  task automatic model_step();
    logic        stop_i;
    logic        be;
    logic [31:0] ba;
    stop_i = stall[0];
    be     = br_bus[32];
    ba     = br_bus[31:0];
    if (!m_booted) begin
      m_booted = 1'b1;
      m_en     = 1'b1;
      m_pc     = RESET_PC + 32'd4;
    end else if (stop_i) begin
      if (be) begin
        m_pend = 1'b1;
        m_tgt  = ba;
      end
    end else begin
      if (m_pend)  m_pc = m_tgt;
      else if (be) m_pc = ba;
      else         m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end
  endtask

  task automatic chk_all(input string tag);
    chk_eq({tag, "_addr"},  {1'b0, inst_sram_addr}, {1'b0, m_pc});
    chk_eq({tag, "_en"},    {32'd0, inst_sram_en},  {32'd0, m_en});
    chk_eq({tag, "_bus"},   if_to_id_bus,           {m_en, m_pc});
    chk_eq({tag, "_wen"},   {29'd0, inst_sram_wen}, 33'd0);
    chk_eq({tag, "_wdata"}, {1'b0, inst_sram_wdata}, 33'd0);
  endtask

  task automatic cyc(input string tag, input logic st, input logic be, input logic [31:0] ba);
    logic [31:0] r;
    r      = $urandom();
    stall  = {r[4:0], st};
    br_bus = {be, ba};
    @(posedge clk);
    model_step();
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();

    // T1: reset and boot sequence
    repeat (3) @(posedge clk);
    #1;
    chk_all("t1_rst");
    rst = 1'b0;
    chk_all("t1_c0");
    chk_eq("t1_c0_addr_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFBF_FFFC});
    chk_eq("t1_c0_en_k", {32'd0, inst_sram_en}, 33'd0);
    cyc("t1_c1", 1'b1, 1'b1, 32'h1234_5678);
    chk_eq("t1_c1_addr_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
    chk_eq("t1_c1_en_k", {32'd0, inst_sram_en}, 33'd1);
    cyc("t1_c2", 1'b0, 1'b0, 32'd0);
    chk_eq("t1_c2_addr_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});

    // T2: sequential fetch wrapping past the top of the address space
    cyc("t2_a", 1'b0, 1'b1, 32'hFFFF_FFF8);
    chk_eq("t2_a_k", {1'b0, inst_sram_addr}, {1'b0, 32'hFFFF_FFF8});
    cyc("t2_b", 1'b0, 1'b0, 32'h0);
    chk_eq("t2_b_k", {1'b0, inst_sram_addr}, {1'b0, 32'hFFFF_FFFC});
    cyc("t2_c", 1'b0, 1'b0, 32'h0);
    chk_eq("t2_c_k", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_0000});

    // T3: unstalled redirect
    cyc("t3_a", 1'b0, 1'b1, 32'hBFC0_0010);
    cyc("t3_b", 1'b0, 1'b1, 32'hBFC0_0100);
    chk_eq("t3_b_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0100});
    cyc("t3_c", 1'b0, 1'b0, 32'h0);
    chk_eq("t3_c_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});

    // T4: redirects under stall, latest wins
    cyc("t4_s1", 1'b1, 1'b1, 32'h8000_0040);
    chk_eq("t4_s1_hold", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});
    cyc("t4_s2", 1'b1, 1'b1, 32'h8000_0080);
    cyc("t4_s3", 1'b1, 1'b0, 32'h0);
    chk_eq("t4_s3_hold", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0104});
    chk_eq("t4_pend_set", {32'd0, dut.br_pend}, 33'd1);
    cyc("t4_rel", 1'b0, 1'b0, 32'h0);
    chk_eq("t4_rel_k", {1'b0, inst_sram_addr}, {1'b0, 32'h8000_0080});
    chk_eq("t4_pend_clr", {32'd0, dut.br_pend}, 33'd0);

    // T5: latched target beats a branch on the release cycle
    cyc("t5_s", 1'b1, 1'b1, 32'h8000_0080);
    cyc("t5_rel", 1'b0, 1'b1, 32'h9000_0000);
    chk_eq("t5_rel_k", {1'b0, inst_sram_addr}, {1'b0, 32'h8000_0080});
    cyc("t5_seq", 1'b0, 1'b0, 32'h0);

    // T6: asynchronous reset while holding a pending redirect
    cyc("t6_s1", 1'b1, 1'b1, 32'hA000_0000);
    cyc("t6_s2", 1'b1, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("t6_async");
    chk_eq("t6_pend", {32'd0, dut.br_pend}, 33'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = '0;
    br_bus = '0;
    chk_all("t6_c0");
    cyc("t6_c1", 1'b0, 1'b0, 32'h0);
    chk_eq("t6_c1_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
    cyc("t6_c2", 1'b0, 1'b0, 32'h0);
    chk_eq("t6_c2_k", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});

    // Random stall / branch traffic
    for (int i = 0; i < 400; i++) begin
      logic        st;
      logic        be;
      logic [31:0] ba;
      st = ($urandom_range(0, 2) == 0);
      be = ($urandom_range(0, 3) == 0);
      ba = $urandom();
      cyc("rnd", st, be, ba);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
